// File: rtl/id_stage_ctrl.sv
// rtl/id_stage_ctrl.sv - MIPS ID stage: IF->ID register, decode, forwarding, hazards, branch resolve
module id_stage_ctrl #(
    parameter int FWD_STAGES = 2,
    parameter int FWD_W      = 2,
    parameter int MULDIV_LAT = 33,
    parameter int CNT_W      = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    if_to_id_valid,
    input  logic [31:0]             if_inst,
    input  logic [31:0]             if_pc,
    output logic                    id_allowin,
    input  logic                    flush,
    input  logic                    ex_allowin,
    output logic                    id_to_ex_valid,
    output logic [31:0]             ex_pc,
    output logic [14:0]             ex_alu_op,
    output logic [4:0]              ex_dest,
    output logic [31:0]             ex_imm,
    output logic                    ex_aluimm,
    output logic                    ex_shift,
    output logic                    ex_is_load,
    output logic                    ex_is_store,
    output logic                    ex_is_muldiv,
    output logic                    ex_ri,
    output logic [FWD_W-1:0]        fwd_a_sel,
    output logic [FWD_W-1:0]        fwd_b_sel,
    input  logic [5*FWD_STAGES-1:0] fwd_dest,
    input  logic [FWD_STAGES-1:0]   fwd_valid,
    input  logic [FWD_STAGES-1:0]   fwd_is_load,
    input  logic [31:0]             rs_data,
    input  logic [31:0]             rt_data,
    output logic                    br_redirect,
    output logic [31:0]             br_target
);

    localparam int OP_ADDU = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_SUBU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_OR   = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_NOR  = 7;
    localparam int OP_SLT  = 8;
    localparam int OP_SLTU = 9;
    localparam int OP_SLL  = 10;
    localparam int OP_SRL  = 11;
    localparam int OP_SRA  = 12;
    localparam int OP_LUI  = 13;
    localparam int OP_JB   = 14;

    logic             id_valid_q, id_valid_d;
    logic [31:0]      id_inst_q, id_inst_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic       sext, is_hilo, is_beq, is_bne, is_j, is_jal, is_jr;
    logic       a_load, b_load, load_use, br_hazard, hilo_hazard, ready_go, fire, taken;
    logic [31:0] pc_plus4;

    assign opcode = id_inst_q[31:26];
    assign funct  = id_inst_q[5:0];
    assign rs     = id_inst_q[25:21];
    assign rt     = id_inst_q[20:16];
    assign rd     = id_inst_q[15:11];
    assign ex_pc  = id_pc_q;

    always_comb begin
        ex_alu_op    = '0;
        ex_dest      = 5'd0;
        ex_aluimm    = 1'b0;
        ex_shift     = 1'b0;
        ex_is_load   = 1'b0;
        ex_is_store  = 1'b0;
        ex_is_muldiv = 1'b0;
        ex_ri        = 1'b0;
        sext         = 1'b0;
        is_hilo      = 1'b0;
        is_beq       = 1'b0;
        is_bne       = 1'b0;
        is_j         = 1'b0;
        is_jal       = 1'b0;
        is_jr        = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: begin ex_alu_op[OP_ADD]  = 1'b1; ex_dest = rd; end
                    6'h21: begin ex_alu_op[OP_ADDU] = 1'b1; ex_dest = rd; end
                    6'h22: begin ex_alu_op[OP_SUB]  = 1'b1; ex_dest = rd; end
                    6'h23: begin ex_alu_op[OP_SUBU] = 1'b1; ex_dest = rd; end
                    6'h24: begin ex_alu_op[OP_AND]  = 1'b1; ex_dest = rd; end
                    6'h25: begin ex_alu_op[OP_OR]   = 1'b1; ex_dest = rd; end
                    6'h26: begin ex_alu_op[OP_XOR]  = 1'b1; ex_dest = rd; end
                    6'h27: begin ex_alu_op[OP_NOR]  = 1'b1; ex_dest = rd; end
                    6'h2a: begin ex_alu_op[OP_SLT]  = 1'b1; ex_dest = rd; end
                    6'h2b: begin ex_alu_op[OP_SLTU] = 1'b1; ex_dest = rd; end
                    // shamt forms take operand A from the immediate; *v forms use rs
                    6'h00, 6'h04: begin ex_alu_op[OP_SLL] = 1'b1; ex_dest = rd; ex_shift = (funct == 6'h00); end
                    6'h02, 6'h06: begin ex_alu_op[OP_SRL] = 1'b1; ex_dest = rd; ex_shift = (funct == 6'h02); end
                    6'h03, 6'h07: begin ex_alu_op[OP_SRA] = 1'b1; ex_dest = rd; ex_shift = (funct == 6'h03); end
                    6'h08:               is_jr = 1'b1;
                    6'h10, 6'h12: begin  is_hilo = 1'b1; ex_dest = rd; end
                    6'h18, 6'h19, 6'h1a, 6'h1b: ex_is_muldiv = 1'b1;
                    default:             ex_ri = 1'b1;
                endcase
            end
            6'h02: is_j = 1'b1;
            6'h03: begin is_jal = 1'b1; ex_alu_op[OP_JB] = 1'b1; ex_dest = 5'd31; end
            6'h04: begin is_beq = 1'b1; sext = 1'b1; end
            6'h05: begin is_bne = 1'b1; sext = 1'b1; end
            6'h08: begin ex_alu_op[OP_ADD]  = 1'b1; ex_dest = rt; ex_aluimm = 1'b1; sext = 1'b1; end
            6'h09: begin ex_alu_op[OP_ADDU] = 1'b1; ex_dest = rt; ex_aluimm = 1'b1; sext = 1'b1; end
            6'h0a: begin ex_alu_op[OP_SLT]  = 1'b1; ex_dest = rt; ex_aluimm = 1'b1; sext = 1'b1; end
            6'h0b: begin ex_alu_op[OP_SLTU] = 1'b1; ex_dest = rt; ex_aluimm = 1'b1; sext = 1'b1; end
            6'h0c: begin ex_alu_op[OP_AND]  = 1'b1; ex_dest = rt; ex_aluimm = 1'b1; end
            6'h0d: begin ex_alu_op[OP_OR]   = 1'b1; ex_dest = rt; ex_aluimm = 1'b1; end
            6'h0e: begin ex_alu_op[OP_XOR]  = 1'b1; ex_dest = rt; ex_aluimm = 1'b1; end
            6'h0f: begin ex_alu_op[OP_LUI]  = 1'b1; ex_dest = rt; ex_aluimm = 1'b1; end
            6'h23: begin ex_alu_op[OP_ADDU] = 1'b1; ex_dest = rt; ex_aluimm = 1'b1; sext = 1'b1; ex_is_load = 1'b1; end
            6'h2b: begin ex_alu_op[OP_ADDU] = 1'b1; ex_aluimm = 1'b1; sext = 1'b1; ex_is_store = 1'b1; end
            default: ex_ri = 1'b1;
        endcase
    end

    assign ex_imm = sext ? {{16{id_inst_q[15]}}, id_inst_q[15:0]} : {16'h0000, id_inst_q[15:0]};

    // Scan from the far stage down so the nearest matching stage wins
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        a_load    = 1'b0;
        b_load    = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (fwd_valid[k] && fwd_dest[5*k +: 5] == rs && rs != 5'd0) begin
                fwd_a_sel = FWD_W'(k + 1);
                a_load    = fwd_is_load[k];
            end
            if (fwd_valid[k] && fwd_dest[5*k +: 5] == rt && rt != 5'd0) begin
                fwd_b_sel = FWD_W'(k + 1);
                b_load    = fwd_is_load[k];
            end
        end
    end

    assign load_use    = a_load | b_load;
    assign br_hazard   = ((is_beq | is_bne) & (fwd_a_sel == FWD_W'(1) | fwd_b_sel == FWD_W'(1)))
                       | (is_jr & fwd_a_sel == FWD_W'(1));
    assign hilo_hazard = (is_hilo | ex_is_muldiv) & (cnt_q != '0);
    assign ready_go    = ~(load_use | br_hazard | hilo_hazard);

    assign id_allowin     = ~id_valid_q | (ready_go & ex_allowin);
    assign id_to_ex_valid = id_valid_q & ready_go & ~flush;
    assign fire           = id_to_ex_valid & ex_allowin;

    assign pc_plus4    = id_pc_q + 32'd4;
    assign taken       = (is_beq & (rs_data == rt_data)) | (is_bne & (rs_data != rt_data))
                       | is_j | is_jal | is_jr;
    assign br_redirect = fire & taken;
    assign br_target   = is_jr          ? rs_data :
                         (is_j | is_jal) ? {pc_plus4[31:28], id_inst_q[25:0], 2'b00} :
                                           pc_plus4 + {ex_imm[29:0], 2'b00};

    always_comb begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (id_allowin) begin
            id_valid_d = if_to_id_valid;
            if (if_to_id_valid) begin
                id_inst_d = if_inst;
                id_pc_d   = if_pc;
            end
        end
        // The HI/LO unit keeps running across a flush, so the counter ignores it
        if (fire && ex_is_muldiv)
            cnt_d = CNT_W'(MULDIV_LAT);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
        else
            cnt_d = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= 32'd0;
            id_pc_q    <= 32'd0;
            cnt_q      <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Registered instruction-decode stage controller for the 5-stage MIPS pipeline.
- Holds the IF->ID pipeline register and decodes the instruction into the EX control bundle.
- Detects load-use and HI/LO hazards, generates forwarding selects over a parametrised number of downstream stages, and resolves branches/jumps in ID with a one-cycle redirect pulse.
- Sits between the fetch stage and the EX pipeline register and uses the allowin/valid handshake.

Parameters:
- FWD_STAGES, 2: number of downstream stages that can forward. Index 0 = EX, 1 = MEM, and so on.
- FWD_W, 2: width of one forward select. Must satisfy FWD_W >= clog2(FWD_STAGES+1).
- MULDIV_LAT, 33: cycles the HI/LO unit stays busy after a mult/multu/div/divu issues.
- CNT_W, 6: width of the HI/LO busy counter. Must satisfy CNT_W >= clog2(MULDIV_LAT+1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- if_to_id_valid  in  1  fetch presents an instruction
- if_inst  in  32  fetched instruction
- if_pc  in  32  PC of fetched instruction
- id_allowin  out  1  ID can accept an instruction this cycle
- flush  in  1  exception/eret flush; kills the instruction held in ID
- ex_allowin  in  1  EX can accept this cycle
- id_to_ex_valid  out  1  decoded bundle valid
- ex_pc  out  32  PC of the decoded instruction
- ex_alu_op  out  15  one-hot ALU op: ADDU, ADD, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, JB
- ex_dest  out  5  destination register; 0 when the instruction does not write the regfile; 31 for jal
- ex_imm  out  32  immediate, sign- or zero-extended per opcode
- ex_aluimm  out  1  ALU operand B is the immediate
- ex_shift  out  1  ALU operand A is shamt
- ex_is_load  out  1  lw
- ex_is_store  out  1  sw
- ex_is_muldiv  out  1  mult/multu/div/divu
- ex_ri  out  1  reserved-instruction flag
- fwd_a_sel  out  FWD_W  rs source: 0 = regfile, k+1 = stage k
- fwd_b_sel  out  FWD_W  rt source, same encoding
- fwd_dest  in  5*FWD_STAGES  destination register of each downstream stage
- fwd_valid  in  FWD_STAGES  stage holds a valid writing instruction
- fwd_is_load  in  FWD_STAGES  stage result is a load not yet returned
- rs_data  in  32  forwarded rs value
- rt_data  in  32  forwarded rt value
- br_redirect  out  1  one-cycle pulse: taken branch/jump
- br_target  out  32  redirect target

Behaviour:
Pipeline register and handshake
- ID register = id_valid, id_inst, id_pc.
- id_allowin = !id_valid | (id_ready_go & ex_allowin).
- On if_to_id_valid & id_allowin, the register loads if_inst and if_pc; otherwise it holds.
- flush clears id_valid the next edge and has priority over a load.
- id_to_ex_valid = id_valid & id_ready_go & !flush. All ex_* outputs are combinational from the ID register.
- Reset: id_valid=0, id_inst=0, id_pc=0, busy counter=0. Consequently id_to_ex_valid=0, br_redirect=0, id_allowin=1, and fwd selects are 0.

Decode
- Covers add/addu/sub/subu/and/or/xor/nor/slt/sltu, sll/srl/sra/sllv/srlv/srav, addi/addiu/andi/ori/xori/lui/slti/sltiu, lw/sw, beq/bne, j/jal/jr, mult/multu/div/divu/mfhi/mflo.
- Any other encoding sets ex_ri=1 and ex_dest=0.
- sext=1 for addi/addiu/slti/sltiu/lw/sw/beq/bne; zero-extension otherwise.

Forwarding
- For rs (and likewise rt), the selected stage is the lowest k with fwd_valid[k] & fwd_dest[k]==rs & rs!=0.
- Select = k+1; if no stage matches, select = 0.

Stall (id_ready_go = 0) when any of the following holds:
- load-use: the selected stage has fwd_is_load=1;
- branch/jr source hazard: a beq/bne/jr source's selected stage is index 0;
- HI/LO hazard: mfhi/mflo/mult/div is in ID and busy counter != 0.

HI/LO busy counter
- Loads MULDIV_LAT when a muldiv instruction fires (id_to_ex_valid & ex_allowin).
- Otherwise it decrements to 0 and saturates there.
- The counter is not cleared by flush.

Branches and jumps
- On fire, br_redirect=1 for exactly one cycle if the branch/jump is taken (beq with rs_data==rt_data, bne with inequality, j, jal, jr).
- br_target:
  - beq/bne: pc+4+(sext(imm)<<2)
  - j/jal: {pc+4[31:28], idx, 2'b00}
  - jr: rs_data
- No redirect while stalled or flushed.
- The delay-slot instruction already in IF is not killed.

Test Plan:
- Reset asserted mid-stream while id_valid=1 -> id_to_ex_valid=0, br_redirect=0, and id_allowin=1 immediately (asynchronous); counter reads 0 after release.
- lw $2 in EX (fwd_is_load[0]=1, dest 2), then addu $3,$2,$4 in ID -> id_to_ex_valid=0 for 1 cycle. Next cycle, with the load now in MEM and not flagged as load, fwd_a_sel=2 and id_to_ex_valid=1.
- Both stages write $5 (EX and MEM) and the ID instruction reads $5 -> fwd_a_sel=1, because the nearest stage wins.
- beq at pc 0x00400000, imm 0x0003, rs_data=rt_data=7, fires -> br_redirect single pulse, br_target=0x00400010. The same case with unequal data -> no pulse.
- div fires, then mflo follows immediately -> mflo held 33 cycles with id_allowin=0; it fires on cycle 34.
- flush asserted while ID holds a stalled jr -> id_valid=0 the next cycle, no redirect, and id_allowin=1.
